norm32_seq: RTL and testbench



---
 rtl/norm32_seq.sv | 117 +++++++++++
 tb/tb_norm32_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/norm32_seq.sv
// Sequential 32-bit normalizer: shifts left by 2 or 1 per cycle until normalized, reporting clz/cls.
// Optional macro NORM_SHIFT4_EN adds a highest-priority 4-bit step (same results, lower latency).
module norm32_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic             signmode,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    count,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int MSB = WIDTH - 1;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             mode_q;
    logic             zpend_q;
    logic [WIDTH-1:0] out_q;
    logic [CW-1:0]    count_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       step_d;
    int unsigned      cnt_w;

    // Step selection; the count caps keep zero-filled bits from ever being examined.
    always_comb begin
        step_d = '0;
        cnt_w  = 32'(cnt_q);
        if (!mode_q) begin
`ifdef NORM_SHIFT4_EN
            if (acc_q[MSB -: 4] == '0 && cnt_w + 4 <= WIDTH)
                step_d = 3'd4;
            else
`endif
            if (acc_q[MSB -: 2] == '0 && cnt_w + 2 <= WIDTH)
                step_d = 3'd2;
            else if (!acc_q[MSB] && cnt_w + 1 <= WIDTH)
                step_d = 3'd1;
        end else begin
`ifdef NORM_SHIFT4_EN
            if ((acc_q[MSB -: 5] == '0 || acc_q[MSB -: 5] == '1) && cnt_w + 4 <= WIDTH - 1)
                step_d = 3'd4;
            else
`endif
            if ((acc_q[MSB -: 3] == '0 || acc_q[MSB -: 3] == '1) && cnt_w + 2 <= WIDTH - 1)
                step_d = 3'd2;
            else if (acc_q[MSB] == acc_q[MSB-1] && cnt_w + 1 <= WIDTH - 1)
                step_d = 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            zpend_q <= 1'b0;
            out_q   <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= in;
                        cnt_q   <= '0;
                        mode_q  <= signmode;
                        zpend_q <= (in == '0);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (step_d != '0) begin
                        acc_q <= acc_q << step_d;
                        cnt_q <= cnt_q + CW'(step_d);
                    end else begin
                        // zero is held with out/count and only updated alongside them
                        out_q   <= acc_q;
                        count_q <= cnt_q;
                        zero_q  <= zpend_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out   = out_q;
    assign count = count_q;
    assign zero  = zero_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_norm32_seq.sv
// Self-checking bench for norm32_seq: directed cases plus randomized operands against a clz/cls model.
module tb_norm32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] in;
    logic        signmode;
    logic [31:0] out;
    logic [5:0]  count;
    logic        zero;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_err    = 0;

    norm32_seq #(.WIDTH(32), .CW(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in(in), .signmode(signmode),
        .out(out), .count(count), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: count leading zeros, or leading bits equal to the sign (excluding the sign).
    function automatic int m_count(input logic [31:0] v, input bit sm);
        int n = 0;
        if (!sm) begin
            for (int i = 31; i >= 0; i--) begin
                if (v[i]) break;
                n++;
            end
        end else begin
            for (int i = 30; i >= 0; i--) begin
                if (v[i] != v[31]) break;
                n++;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] m_out(input logic [31:0] v, input int c);
        return (c >= 32) ? 32'h0 : (v << c);
    endfunction

    // Greedy largest-first decomposition of the count into available step sizes, plus the final cycle.
    function automatic int m_lat(input int c);
`ifdef NORM_SHIFT4_EN
        return c / 4 + (c % 4) / 2 + (c % 2) + 1;
`else
        return (c + 1) / 2 + 1;
`endif
    endfunction

    // Issues one request at the next negedge and waits (bounded) for done.
    task automatic run_op(input logic [31:0] v, input bit sm,
                          output logic [31:0] o, output logic [5:0] c, output logic z,
                          output int lat, output bit timeout);
        @(negedge clk);
        start = 1'b1; in = v; signmode = sm;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
        o = out; c = count; z = zero;
    endtask

    task automatic check_op(input string name, input logic [31:0] v, input bit sm);
        logic [31:0] o;
        logic [5:0]  c;
        logic        z;
        int          lat, ec;
        bit          to;
        run_op(v, sm, o, c, z, lat, to);
        ec = m_count(v, sm);
        n_checks++;
        if (to) begin
            n_err++;
            $display("FAIL %s timeout: in=%h sm=%0d no done within 40 cycles", name, v, sm);
            return;
        end
        if (o !== m_out(v, ec) || c !== 6'(ec) || z !== (v == 0) || lat != m_lat(ec) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: in=%h sm=%0d got out=%h count=%0d zero=%0d lat=%0d busy=%0d want out=%h count=%0d zero=%0d lat=%0d busy=0",
                     name, v, sm, o, c, z, lat, busy, m_out(v, ec), ec, (v == 0), m_lat(ec));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in = '0; signmode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out !== 32'h0 || count !== 6'h0 || zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: out=%h count=%0d zero=%0d busy=%0d done=%0d want all 0",
                     out, count, zero, busy, done);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_directed();
        check_op("u_00010000", 32'h0001_0000, 1'b0);
        check_op("u_zero",     32'h0000_0000, 1'b0);
        check_op("u_msb",      32'h8000_0000, 1'b0);
        check_op("u_one",      32'h0000_0001, 1'b0);
        check_op("s_ffffffff", 32'hFFFF_FFFF, 1'b1);
        check_op("s_00000003", 32'h0000_0003, 1'b1);
        check_op("s_80000000", 32'h8000_0000, 1'b1);
        check_op("s_zero",     32'h0000_0000, 1'b1);
        check_op("s_40000000", 32'h4000_0000, 1'b1);
        check_op("s_c0000000", 32'hC000_0000, 1'b1);
    endtask

    task automatic test_done_pulse();
        check_op("pulse_op", 32'h0000_0F00, 1'b0);
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse: done=%0d busy=%0d one cycle later, want 0/0", done, busy);
        end
    endtask

    task automatic test_hold();
        logic [31:0] o_prev;
        logic [5:0]  c_prev;
        logic        z_prev;
        check_op("hold_first", 32'h0000_0000, 1'b0);
        o_prev = out; c_prev = count; z_prev = zero;
        @(negedge clk);
        start = 1'b1; in = 32'h0000_0010; signmode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || out !== o_prev || count !== c_prev || zero !== z_prev) begin
            n_err++;
            $display("FAIL hold: busy=%0d out=%h count=%0d zero=%0d want busy=1 out=%h count=%0d zero=%0d",
                     busy, out, count, zero, o_prev, c_prev, z_prev);
        end
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (done !== 1'b1 || out !== 32'h8000_0000 || count !== 6'd27 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL hold_result: done=%0d out=%h count=%0d zero=%0d want 1 80000000 27 0",
                     done, out, count, zero);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        start = 1'b1; in = 32'h0000_0001; signmode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1; in = 32'hF000_0000; signmode = 1'b1;
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        lat = 6;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1 lat++;
        end
        n_checks++;
        if (done !== 1'b1 || out !== 32'h8000_0000 || count !== 6'd31 || lat != m_lat(31)) begin
            n_err++;
            $display("FAIL busy_ignore: done=%0d out=%h count=%0d lat=%0d want 1 80000000 31 lat=%0d",
                     done, out, count, lat, m_lat(31));
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore_queue: busy=%0d after done, want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        bit seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1; in = 32'h0000_0001; signmode = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out !== 32'h0 || count !== 6'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: out=%h count=%0d busy=%0d done=%0d want 0 0 0 0",
                     out, count, busy, done);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1 if (done) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort_nodone: done_seen=%0d busy=%0d want 0 0", seen_done, busy);
        end
        check_op("after_abort", 32'h4000_0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        // run_op issues at the negedge following done, so each request lands on the done cycle.
        check_op("b2b_a", 32'h0000_00FF, 1'b0);
        check_op("b2b_b", 32'hFFFF_0000, 1'b1);
        check_op("b2b_c", 32'h0000_0000, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] v;
        bit          sm;
        for (int i = 0; i < 200; i++) begin
            v  = $urandom;
            v  = (v | 32'h1) >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) v = '0;
            sm = 1'($urandom_range(0, 1));
            if (sm && $urandom_range(0, 1) == 1) v = ~v;
            check_op("random", v, sm);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_done_pulse();
        test_hold();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
